gate3_tt_sequencer: RTL and testbench
=====================================

GATE3_TT_SEQUENCER -- requirements
Module: gate3_tt_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles each input vector is held before Y is sampled; legal range 1..15.
REQ-002 Parameter EXPECT_MASK, default 8'h80, expected Y per vector index, where bit i is the expected Y for vector i (8'h80 is the 3-input AND truth table).
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full truth-table sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel a sweep in progress.
REQ-007 dut_y  input  1  output of the gate under test.
REQ-008 dut_a, dut_b, dut_c  output  1 each  gate inputs; dut_a = idx[2], dut_b = idx[1], dut_c = idx[0].
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 fail_vec  output  8  bit i set when vector i mismatched EXPECT_MASK[i].
REQ-012 err_count  output  4  number of set bits in fail_vec, range 0..8.
REQ-013 pass  output  1  high when the last completed sweep had err_count == 0.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE: when start=1 and abort=0, SHALL clear idx, the settle counter, fail_vec, err_count and pass, then enter SETTLE.
REQ-016 IDLE: dut_a/b/c SHALL be 0, busy SHALL be 0, and result outputs SHALL hold their last values.
REQ-017 SETTLE: SHALL drive vector idx, increment the settle counter, and enter SAMPLE when the counter reaches SETTLE_CYCLES-1.
REQ-018 SAMPLE: SHALL compare dut_y against EXPECT_MASK[idx] and, on mismatch, set fail_vec[idx] and increment err_count.
REQ-019 SAMPLE with idx<7: SHALL increment idx, clear the settle counter, and enter SETTLE; with idx==7: SHALL enter DONE.
REQ-020 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles, and the vector pattern SHALL stay stable through its SAMPLE cycle.
REQ-021 A sweep SHALL take 8*(SETTLE_CYCLES+1) cycles from the first SETTLE cycle to DONE entry (default 24).
REQ-022 DONE: done=1 for exactly one cycle, pass SHALL be updated with (err_count==0) including the final sample, and the FSM SHALL return to IDLE.
REQ-023 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-024 start asserted while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 abort in SETTLE or SAMPLE SHALL force IDLE on the next edge, with no done pulse, partial fail_vec/err_count retained, and pass forced to 0.
REQ-026 start and abort both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-027 idx SHALL be 3 bits and SHALL never wrap past 7 within a sweep; the settle counter SHALL be 4 bits.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, idx=0, counter=0, dut_a/b/c=0, busy=0, done=0, fail_vec=0, err_count=0 and pass=0.
REQ-029 Reset asserted mid-sweep SHALL discard the sweep, with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-031 Shared package gate_tt_pkg SHALL hold the state enum, NUM_VECTORS=8, and the expected-mask constants AND3_EXPECT=8'h80, OR3_EXPECT=8'hFE, NAND3_EXPECT=8'h7F, NOR3_EXPECT=8'h01 and XOR3_EXPECT=8'h96.
REQ-032 The settle counter SHALL be a sub-module, gate_tt_settle_timer (load/clear, count, terminal flag).
REQ-033 The gate under test SHALL be external; the sequencer SHALL contain no gate instance.

Verification
REQ-034 Default parameters with a correct AND3 on dut_y, pulse start -> done 24 cycles after the first SETTLE cycle, fail_vec=8'h00, err_count=0, pass=1.
REQ-035 dut_y tied to 0 -> fail_vec=8'h80, err_count=1, pass=0.
REQ-036 EXPECT_MASK=AND3_EXPECT with an OR3 on dut_y -> fail_vec=8'h7E, err_count=6, pass=0.
REQ-037 SETTLE_CYCLES=1, with start held high throughout -> sweeps back-to-back, each 16 cycles to done, one done per sweep, start ignored while busy.
REQ-038 abort at vector 3 with dut_y tied to 1 -> IDLE next cycle, no done, fail_vec=8'h07, err_count=3, pass=0, dut_a/b/c=0.
REQ-039 rst_n low mid-sweep (vector 5) -> all outputs 0 asynchronously; a start after release gives a full clean sweep.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared definitions for the 3-input gate truth-table sequencer.
package gate_tt_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    // One vector per row of a 3-input truth table
    localparam int unsigned NUM_VECTORS = 8;

    // Expected-output masks: bit i is the gate output for inputs {a,b,c} = i
    localparam logic [7:0] AND3_EXPECT  = 8'h80;
    localparam logic [7:0] OR3_EXPECT   = 8'hFE;
    localparam logic [7:0] NAND3_EXPECT = 8'h7F;
    localparam logic [7:0] NOR3_EXPECT  = 8'h01;
    localparam logic [7:0] XOR3_EXPECT  = 8'h96;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Settle counter: counts cycles a vector has been held and flags the last one.
module gate_tt_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_terminal
);

    localparam logic [3:0] TERMINAL = 4'(SETTLE_CYCLES - 1);

    logic [3:0] count;

    // Count while enabled, clear on request, saturate at the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_terminal) begin
            count <= count + 4'd1;
        end
    end

    assign at_terminal = (count == TERMINAL);

endmodule

// File: rtl/gate3_tt_sequencer.sv
// Drives all eight input vectors into an external 3-input gate, waits for each
// to settle, samples the gate output and records mismatches against EXPECT_MASK.
module gate3_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECT_MASK   = AND3_EXPECT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic [7:0] fail_vec,
    output logic [3:0] err_count,
    output logic       pass
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

    tt_state_e  state;
    logic [2:0] idx;
    logic       settle_done;
    logic       sample_miss;
    logic [3:0] err_next;

    gate_tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state != SETTLE),
        .en         (state == SETTLE),
        .at_terminal(settle_done)
    );

    // Compare the gate output against the expected bit for the current vector
    always_comb begin
        sample_miss = (dut_y != EXPECT_MASK[idx]);
        err_next    = err_count + (sample_miss ? 4'd1 : 4'd0);
    end

    // Sweep FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            fail_vec  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx       <= '0;
                        fail_vec  <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_done) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (sample_miss) begin
                            fail_vec[idx] <= 1'b1;
                        end
                        err_count <= err_next;
                        if (idx == LAST_IDX) begin
                            // pass uses err_next so the final sample is counted
                            // and the verdict is visible alongside done
                            pass  <= (err_next == 4'd0);
                            state <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status and vector outputs decoded from the FSM
    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
        {dut_a, dut_b, dut_c} = busy ? idx : 3'b000;
    end

endmodule

// File: tb/tb_gate3_tt_sequencer.sv
// Self-checking bench for gate3_tt_sequencer with a behavioural gate model.
module tb_gate3_tt_sequencer;
    import gate_tt_pkg::*;

    localparam int unsigned S0    = 2;
    localparam int unsigned S1    = 1;
    localparam logic [7:0]  MASK0 = AND3_EXPECT;

    localparam int unsigned M_AND  = 0;
    localparam int unsigned M_OR   = 1;
    localparam int unsigned M_ZERO = 2;
    localparam int unsigned M_ONE  = 3;

    typedef struct {
        logic [7:0]  fv;
        logic [3:0]  ec;
        logic        ps;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic clk;
    logic rst_n;

    logic       start0, abort0, y0, a0, b0, c0, busy0, done0, pass0;
    logic [7:0] fv0;
    logic [3:0] ec0;
    logic       start1, abort1, y1, a1, b1, c1, busy1, done1, pass1;
    logic [7:0] fv1;
    logic [3:0] ec1;

    int unsigned y_mode;

    function automatic logic gate_model(input int unsigned mode, input logic [2:0] v);
        case (mode)
            M_AND:   return v[2] & v[1] & v[0];
            M_OR:    return v[2] | v[1] | v[0];
            M_ZERO:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t compute_exp(input int unsigned mode, input int unsigned nvec,
                                         input int unsigned cyc);
        exp_t       e;
        logic [7:0] m;
        m     = MASK0;
        e.fv  = '0;
        e.ec  = '0;
        e.cyc = cyc;
        for (int i = 0; i < int'(nvec); i++) begin
            if (gate_model(mode, 3'(i)) !== m[i]) begin
                e.fv[i] = 1'b1;
                e.ec    = e.ec + 4'd1;
            end
        end
        e.ps = (e.ec == 4'd0);
        return e;
    endfunction

    always_comb y0 = gate_model(y_mode, {a0, b0, c0});
    always_comb y1 = gate_model(M_AND, {a1, b1, c1});

    gate3_tt_sequencer #(
        .SETTLE_CYCLES(S0),
        .EXPECT_MASK  (MASK0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_y(y0),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .busy(busy0), .done(done0),
        .fail_vec(fv0), .err_count(ec0), .pass(pass0)
    );

    gate3_tt_sequencer #(
        .SETTLE_CYCLES(S1),
        .EXPECT_MASK  (MASK0)
    ) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_y(y1),
        .dut_a(a1), .dut_b(b1), .dut_c(c1), .busy(busy1), .done(done1),
        .fail_vec(fv1), .err_count(ec1), .pass(pass1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        y_mode = M_AND;
        #3;
        n_checks++;
        if ({busy0, done0, a0, b0, c0, fv0, ec0, pass0} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: got busy=%b done=%b abc=%b%b%b fv=%h ec=%0d pass=%b, want all 0",
                     busy0, done0, a0, b0, c0, fv0, ec0, pass0);
        end
        n_checks++;
        if ({busy1, done1, a1, b1, c1, fv1, ec1, pass1} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got busy=%b done=%b abc=%b%b%b fv=%h ec=%0d pass=%b, want all 0",
                     busy1, done1, a1, b1, c1, fv1, ec1, pass1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; runs one full sweep on the default instance
    task automatic run_sweep(input int unsigned mode, input bit poke, input string name);
        exp_t        e;
        int unsigned k;
        bit          timeout;
        y_mode = mode;
        sb.push_back(compute_exp(mode, NUM_VECTORS, NUM_VECTORS * (S0 + 1)));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: got %b, want 1", name, busy0);
        end
        k = 0;
        timeout = 0;
        while (done0 !== 1'b1) begin
            n_checks++;
            if ({a0, b0, c0} !== 3'(k / (S0 + 1))) begin
                n_fail++;
                $display("FAIL %s_vector k=%0d: got %b%b%b, want %0d", name, k, a0, b0, c0, k / (S0 + 1));
            end
            if (poke && k == 5) start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            k++;
            if (k > 200) begin
                timeout = 1;
                break;
            end
        end
        e = sb.pop_front();
        if (timeout) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, want %0d", name, k, e.cyc);
            return;
        end
        n_checks++;
        if (k !== e.cyc) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, k, e.cyc);
        end
        n_checks++;
        if (fv0 !== e.fv) begin
            n_fail++;
            $display("FAIL %s_fail_vec: got %h, want %h", name, fv0, e.fv);
        end
        n_checks++;
        if (ec0 !== e.ec) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d, want %0d", name, ec0, e.ec);
        end
        n_checks++;
        if (pass0 !== e.ps) begin
            n_fail++;
            $display("FAIL %s_pass: got %b, want %b", name, pass0, e.ps);
        end
        @(negedge clk);
        n_checks++;
        if ({done0, busy0, pass0, fv0} !== {1'b0, 1'b0, e.ps, e.fv}) begin
            n_fail++;
            $display("FAIL %s_after_done: got done=%b busy=%b pass=%b fv=%h, want 0 0 %b %h",
                     name, done0, busy0, pass0, fv0, e.ps, e.fv);
        end
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_no_requeue: got busy=%b, want 0", name, busy0);
        end
    endtask

    task automatic test_and3_pass();   run_sweep(M_AND,  0, "and3");        endtask
    task automatic test_stuck_low();   run_sweep(M_ZERO, 0, "stuck_low");   endtask
    task automatic test_or3_on_and();  run_sweep(M_OR,   0, "or3_on_and");  endtask
    task automatic test_start_busy();  run_sweep(M_AND,  1, "start_busy");  endtask

    task automatic test_start_abort_idle();
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy=%b, want 0", busy0);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        exp_t        e;
        int unsigned k;
        bit          seen_done;
        y_mode = M_ONE;
        sb.push_back(compute_exp(M_ONE, 3, 0));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while ({a0, b0, c0} !== 3'd3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL abort_wait: vector 3 not reached in %0d cycles, want < 100", k);
            return;
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_checks++;
        if ({busy0, done0, a0, b0, c0} !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b abc=%b%b%b, want all 0",
                     busy0, done0, a0, b0, c0);
        end
        n_checks++;
        if ({fv0, ec0, pass0} !== {e.fv, e.ec, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_results: got fv=%h ec=%0d pass=%b, want fv=%h ec=%0d pass=0",
                     fv0, ec0, pass0, e.fv, e.ec);
        end
        seen_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) seen_done = 1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity=%b, want 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int unsigned t, rise_t, last_done_t, n_done;
        logic        prev_busy, prev_done;
        t = 0; rise_t = 0; last_done_t = 0; n_done = 0;
        prev_busy = 1'b0; prev_done = 1'b0;
        start1 = 1'b1;
        while (n_done < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (busy1 === 1'b1 && prev_busy !== 1'b1) begin
                rise_t = t;
                sb.push_back(compute_exp(M_AND, NUM_VECTORS, NUM_VECTORS * (S1 + 1)));
            end
            if (done1 === 1'b1) begin
                n_checks++;
                if (prev_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_done_width: done high on consecutive cycles at t=%0d", t);
                end
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b2b_unexpected_done: done at t=%0d with no sweep started", t);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (t - rise_t !== e.cyc) begin
                        n_fail++;
                        $display("FAIL b2b_latency: got %0d cycles, want %0d", t - rise_t, e.cyc);
                    end
                    n_checks++;
                    if ({fv1, ec1, pass1} !== {e.fv, e.ec, e.ps}) begin
                        n_fail++;
                        $display("FAIL b2b_results: got fv=%h ec=%0d pass=%b, want fv=%h ec=%0d pass=%b",
                                 fv1, ec1, pass1, e.fv, e.ec, e.ps);
                    end
                end
                if (n_done > 0) begin
                    n_checks++;
                    if (t - last_done_t !== NUM_VECTORS * (S1 + 1) + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles between dones, want %0d",
                                 t - last_done_t, NUM_VECTORS * (S1 + 1) + 2);
                    end
                end
                last_done_t = t;
                n_done++;
            end
            prev_busy = busy1;
            prev_done = done1;
        end
        start1 = 1'b0;
        n_checks++;
        if (n_done !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", n_done);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: got busy=%b after start released, want 0", busy1);
        end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        int unsigned k;
        y_mode = M_ONE;
        e = compute_exp(M_ONE, 5, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while ({a0, b0, c0} !== 3'd5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (fv0 !== e.fv) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got fv=%h at vector 5, want %h", fv0, e.fv);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy0, done0, a0, b0, c0, fv0, ec0, pass0} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got busy=%b done=%b abc=%b%b%b fv=%h ec=%0d pass=%b, want all 0",
                     busy0, done0, a0, b0, c0, fv0, ec0, pass0);
        end
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got done=%b, want 0", done0);
        end
        rst_n = 1'b1;
        run_sweep(M_AND, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_and3_pass();
        test_stuck_low();
        test_or3_on_and();
        test_start_busy();
        test_start_abort_idle();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
